// File: rtl/ps2_rx_fifo_if.sv
// Pin-side and consumer-side signals of the PS/2 receiver FIFO.
// The slave modport is the receiver; the master modport drives the pins and pops codes.
interface ps2_rx_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 3
) ();
  logic                ps2_clk;
  logic                ps2_data;
  logic                rd_en;
  logic                ovf_clr;
  logic [7:0]          data;
  logic                ready;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;
  logic                parity_err;
  logic                frame_err;
  logic                timeout_err;

  modport master (
    output ps2_clk, ps2_data, rd_en, ovf_clr,
    input  data, ready, level, overflow, parity_err, frame_err, timeout_err
  );

  modport slave (
    input  ps2_clk, ps2_data, rd_en, ovf_clr,
    output data, ready, level, overflow, parity_err, frame_err, timeout_err
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver with pin synchronisers, glitch filter, frame timeout and a drop-on-full
// scan-code FIFO with first-word fall-through output.
module ps2_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned TIMEOUT    = 50000
) (
  input logic          clk,
  input logic          rst,
  ps2_rx_fifo_if.slave bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned FW    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StShift, StCheck} state_e;

  logic [1:0]            clk_sync_q, dat_sync_q;
  logic                  filt_q, filt_d, filt_prev_q;
  logic [FW-1:0]         fcnt_q, fcnt_d;
  logic                  strobe;
  state_e                state_q, state_d;
  logic [9:0]            sr_q, sr_d;
  logic [3:0]            bcnt_q, bcnt_d;
  logic [TW-1:0]         to_q, to_d;
  logic                  perr_q, perr_d, ferr_q, ferr_d, terr_q, terr_d;
  logic                  good, push, pop, full, drop;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [LW-1:0]         level_q, level_d;
  logic                  ovf_q, ovf_d;

  // Filtered clock only follows the pin after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
      else                               fcnt_d = fcnt_q + 1'b1;
    end
  end

  assign strobe = filt_prev_q & ~filt_q;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bcnt_d  = bcnt_q;
    to_d    = '0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    terr_d  = 1'b0;
    good    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (strobe && !dat_sync_q[1]) begin
          state_d = StShift;
          bcnt_d  = '0;
        end
      end
      StShift: begin
        if (strobe) begin
          sr_d   = {dat_sync_q[1], sr_q[9:1]};
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == 4'd9) state_d = StCheck;
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = StIdle;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      StCheck: begin
        // sr_q = {stop, parity, data[7:0]}
        perr_d  = ~(^sr_q[8:0]);
        ferr_d  = ~sr_q[9];
        good    = (^sr_q[8:0]) & sr_q[9];
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign full = (level_q == LW'(DEPTH));
  assign pop  = bus.rd_en && (level_q != '0);
  assign push = good && (!full || pop);
  assign drop = good && full && !pop;

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
    ovf_d = drop ? 1'b1 : (bus.ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
      state_q     <= StIdle;
      sr_q        <= '0;
      bcnt_q      <= '0;
      to_q        <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      terr_q      <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], bus.ps2_clk};
      dat_sync_q  <= {dat_sync_q[0], bus.ps2_data};
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      sr_q        <= sr_d;
      bcnt_q      <= bcnt_d;
      to_q        <= to_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      terr_q      <= terr_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: data is gated by ready.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= sr_q[7:0];
  end

  assign bus.ready       = (level_q != '0);
  assign bus.data        = bus.ready ? mem_q[rptr_q] : 8'h00;
  assign bus.level       = level_q;
  assign bus.overflow    = ovf_q;
  assign bus.parity_err  = perr_q;
  assign bus.frame_err   = ferr_q;
  assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: table of single frames, then hand-written sequences
// for overflow, timeout, glitches, reset mid-frame and push+pop while full.
module tb_ps2_rx_fifo;
  localparam int unsigned DL   = 3;
  localparam int unsigned FL   = 4;
  localparam int unsigned TO   = 64;
  localparam int          HALF = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ps2_rx_fifo_if #(.DEPTH_LOG2(DL)) bus ();

  ps2_rx_fifo #(
    .DEPTH_LOG2(DL),
    .FILTER_LEN(FL),
    .TIMEOUT   (TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_perr = 0, n_ferr = 0, n_terr = 0;
  logic [7:0] exp_q [$];
  logic       exp_ovf = 1'b0;

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         stop;
    bit         exp_perr;
    bit         exp_ferr;
    bit         exp_push;
  } vec_t;
  vec_t vecs [5];

  // Count high cycles of each error pulse, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.parity_err)  n_perr++;
    if (bus.frame_err)   n_ferr++;
    if (bus.timeout_err) n_terr++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    bus.ps2_data = b;
    if (glitch) begin
      repeat (3) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (2) @(negedge clk);
      bus.ps2_clk = 1'b1;
      repeat (HALF - 5) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    bus.ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit stop,
                            input bit glitch);
    logic par;
    par = ~(^code) ^ bad_par;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i], glitch);
    send_bit(par, glitch);
    send_bit(stop, 1'b0);
    bus.ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic model_push(input logic [7:0] code);
    if (exp_q.size() < (1 << DL)) exp_q.push_back(code);
    else                          exp_ovf = 1'b1;
  endtask

  task automatic drain(input int n);
    logic [7:0] e;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check("drain_ready", 32'(bus.ready), 32'd1);
      check("drain_data", 32'(bus.data), 32'(e));
      bus.rd_en = 1'b1;
      @(negedge clk);
    end
    bus.rd_en = 1'b0;
    check("drained_ready", 32'(bus.ready), 32'd0);
    check("drained_data", 32'(bus.data), 32'h00);
    check("drained_level", 32'(bus.level), 32'd0);
  endtask

  initial begin
    int p0, f0, t0;
    vecs[0] = '{code: 8'h1C, bad_par: 0, stop: 1, exp_perr: 0, exp_ferr: 0, exp_push: 1};
    vecs[1] = '{code: 8'h1C, bad_par: 1, stop: 1, exp_perr: 1, exp_ferr: 0, exp_push: 0};
    vecs[2] = '{code: 8'hF0, bad_par: 0, stop: 1, exp_perr: 0, exp_ferr: 0, exp_push: 1};
    vecs[3] = '{code: 8'h5A, bad_par: 0, stop: 0, exp_perr: 0, exp_ferr: 1, exp_push: 0};
    vecs[4] = '{code: 8'h33, bad_par: 1, stop: 0, exp_perr: 1, exp_ferr: 1, exp_push: 0};

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    bus.rd_en    = 1'b0;
    bus.ovf_clr  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(bus.data), 32'h00);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_errs", 32'({bus.parity_err, bus.frame_err, bus.timeout_err}), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      p0 = n_perr;
      f0 = n_ferr;
      send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].stop, 1'b0);
      if (vecs[i].exp_push) model_push(vecs[i].code);
      check($sformatf("vec%0d_perr", i), 32'(n_perr - p0), 32'(vecs[i].exp_perr));
      check($sformatf("vec%0d_ferr", i), 32'(n_ferr - f0), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d_level", i), 32'(bus.level), 32'(exp_q.size()));
      check($sformatf("vec%0d_ovf", i), 32'(bus.overflow), 32'(exp_ovf));
    end
    drain(exp_q.size());

    // Nine frames into an eight-deep FIFO
    for (int c = 1; c <= 9; c++) begin
      send_frame(8'(c), 1'b0, 1'b1, 1'b0);
      model_push(8'(c));
    end
    check("ovf_level", 32'(bus.level), 32'd8);
    check("ovf_set", 32'(bus.overflow), 32'(exp_ovf));
    drain(exp_q.size());
    check("ovf_sticky", 32'(bus.overflow), 32'd1);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    check("ovf_clr", 32'(bus.overflow), 32'(exp_ovf));

    // Partial frame abandoned, then a clean frame
    t0 = n_terr;
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    repeat (50) @(negedge clk);
    check("to_early", 32'(n_terr - t0), 32'd0);
    repeat (50) @(negedge clk);
    check("to_pulse", 32'(n_terr - t0), 32'd1);
    check("to_level", 32'(bus.level), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    model_push(8'h5A);
    check("to_next_level", 32'(bus.level), 32'd1);
    drain(exp_q.size());

    // Short low pulses on ps2_clk between real edges
    p0 = n_perr;
    f0 = n_ferr;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    model_push(8'hA5);
    check("glitch_errs", 32'((n_perr - p0) + (n_ferr - f0)), 32'd0);
    check("glitch_level", 32'(bus.level), 32'd1);
    drain(exp_q.size());

    // Reset in the middle of a frame with one entry queued
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    model_push(8'h3C);
    for (int i = 0; i < 5; i++) send_bit(1'(i == 2), 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(bus.ready), 32'd0);
    check("mid_rst_data", 32'(bus.data), 32'h00);
    check("mid_rst_level", 32'(bus.level), 32'd0);
    check("mid_rst_ovf", 32'(bus.overflow), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    p0 = n_perr;
    f0 = n_ferr;
    t0 = n_terr;
    repeat (150) @(negedge clk);
    check("mid_rst_no_err", 32'((n_perr - p0) + (n_ferr - f0) + (n_terr - t0)), 32'd0);

    // Full FIFO with a pop in the same cycle as the push of a new frame
    for (int c = 1; c <= 8; c++) begin
      send_frame(8'h10 + 8'(c), 1'b0, 1'b1, 1'b0);
      model_push(8'h10 + 8'(c));
    end
    check("full_level", 32'(bus.level), 32'd8);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'(8'h77 >> i), 1'b0);
    send_bit(~(^8'h77), 1'b0);
    bus.ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (7) @(negedge clk);
    check("pp_head", 32'(bus.data), 32'(exp_q.pop_front()));
    exp_q.push_back(8'h77);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    repeat (HALF - 8) @(negedge clk);
    bus.ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    check("pp_level", 32'(bus.level), 32'd8);
    check("pp_ovf", 32'(bus.overflow), 32'd0);
    drain(exp_q.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
